// File: rtl/batch_admission_ctrl.sv
// batch_admission_ctrl: groups ingress transactions into dependency-disjoint batches
// and tags each admitted transaction with the ID of the batch it joined.
module batch_admission_ctrl #(
  parameter int MAX_DEPENDENCIES     = 1024,
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 100,
  parameter int BATCH_ID_WIDTH       = 16,
  localparam int CW = $clog2(MAX_BATCH_SIZE + 1),
  localparam int TW = $clog2(BATCH_TIMEOUT_CYCLES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [63:0]                 s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [63:0]                 m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
  output logic [BATCH_ID_WIDTH-1:0]   m_axis_tdata_batch_id,
  output logic                        batch_done,
  output logic [CW-1:0]               batch_done_size,
  output logic [1:0]                  batch_done_reason,
  output logic [31:0]                 raw_conflicts,
  output logic [31:0]                 waw_conflicts,
  output logic [31:0]                 war_conflicts,
  output logic [31:0]                 batches_closed
);
  typedef enum logic {RUN, CLOSE} state_e;
  state_e                      state_q;
  logic                        pend_valid_q;
  logic [63:0]                 pend_id_q;
  logic [MAX_DEPENDENCIES-1:0] pend_rd_q, pend_wr_q, batch_rd_q, batch_wr_q;
  logic [CW-1:0]               count_q;
  logic [TW-1:0]               timer_q;
  logic [BATCH_ID_WIDTH-1:0]   batch_id_q;
  logic raw, waw, war, conflict, full, out_free, run, admit, idle_run, timeout, close_c, go_close, accept;
  logic [1:0] reason_d;
  assign raw      = |(pend_rd_q & batch_wr_q);
  assign waw      = |(pend_wr_q & batch_wr_q);
  assign war      = |(pend_wr_q & batch_rd_q);
  assign conflict = raw | waw | war;
  assign full     = count_q == CW'(MAX_BATCH_SIZE);
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign run      = state_q == RUN;
  assign admit    = run && pend_valid_q && !conflict && !full && out_free;
  assign close_c  = run && pend_valid_q && (conflict || full);
  assign idle_run = run && !pend_valid_q && count_q != '0;
  assign timeout  = idle_run && timer_q == TW'(BATCH_TIMEOUT_CYCLES - 1);
  assign go_close = close_c || timeout;
  // Stale pend sets are ignored on the timeout path since pend is empty there.
  assign reason_d = close_c ? (conflict ? 2'd1 : 2'd2) : 2'd3;
  assign s_axis_tready = !pend_valid_q || admit;
  assign accept   = s_axis_tvalid && s_axis_tready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_valid_q <= 1'b0;
      pend_id_q <= '0;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
      batch_rd_q <= '0;
      batch_wr_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      batch_id_q <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata_owner_programID <= '0;
      m_axis_tdata_read_dependencies <= '0;
      m_axis_tdata_write_dependencies <= '0;
      m_axis_tdata_batch_id <= '0;
      batch_done <= 1'b0;
      batch_done_size <= '0;
      batch_done_reason <= '0;
      raw_conflicts <= '0;
      waw_conflicts <= '0;
      war_conflicts <= '0;
      batches_closed <= '0;
    end else begin
      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_id_q <= s_axis_tdata_owner_programID;
        pend_rd_q <= s_axis_tdata_read_dependencies;
        pend_wr_q <= s_axis_tdata_write_dependencies;
      end else if (admit) pend_valid_q <= 1'b0;
      if (admit) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata_owner_programID <= pend_id_q;
        m_axis_tdata_read_dependencies <= pend_rd_q;
        m_axis_tdata_write_dependencies <= pend_wr_q;
        m_axis_tdata_batch_id <= batch_id_q;
        batch_rd_q <= batch_rd_q | pend_rd_q;
        batch_wr_q <= batch_wr_q | pend_wr_q;
        count_q <= count_q + 1'b1;
        timer_q <= '0;
      end else if (m_axis_tready) m_axis_tvalid <= 1'b0;
      if (idle_run) timer_q <= timer_q + 1'b1;
      batch_done <= go_close;
      if (go_close) begin
        state_q <= CLOSE;
        batch_done_size <= count_q;
        batch_done_reason <= reason_d;
        batches_closed <= batches_closed + 32'd1;
      end
      if (close_c && raw) raw_conflicts <= raw_conflicts + 32'd1;
      if (close_c && waw) waw_conflicts <= waw_conflicts + 32'd1;
      if (close_c && war) war_conflicts <= war_conflicts + 32'd1;
      if (!run) begin
        state_q <= RUN;
        batch_rd_q <= '0;
        batch_wr_q <= '0;
        count_q <= '0;
        timer_q <= '0;
        batch_id_q <= batch_id_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_batch_admission_ctrl.sv
// tb_batch_admission_ctrl: directed scenarios with hand-computed expectations
// covering admission, each close reason, backpressure and asynchronous reset.
module tb_batch_admission_ctrl;
  localparam int D = 1024;
  logic clk = 1'b0, rst_n = 1'b0;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b1;
  logic [63:0] s_id = '0, m_id;
  logic [D-1:0] s_rd = '0, s_wr = '0, m_rd, m_wr;
  logic [15:0] m_bid;
  logic batch_done;
  logic [3:0] done_size;
  logic [1:0] done_reason;
  logic [31:0] raw_c, waw_c, war_c, closed_c;
  int total = 0, fails = 0;

  batch_admission_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata_owner_programID(s_id),
    .s_axis_tdata_read_dependencies(s_rd), .s_axis_tdata_write_dependencies(s_wr),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata_owner_programID(m_id),
    .m_axis_tdata_read_dependencies(m_rd), .m_axis_tdata_write_dependencies(m_wr),
    .m_axis_tdata_batch_id(m_bid),
    .batch_done(batch_done), .batch_done_size(done_size), .batch_done_reason(done_reason),
    .raw_conflicts(raw_c), .waw_conflicts(waw_c), .war_conflicts(war_c),
    .batches_closed(closed_c)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] bitv(input int i);
    logic [D-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic out_is(input string tag, input logic [63:0] id, input logic [15:0] bid);
    chk({tag, "_valid"}, 64'(m_axis_tvalid), 64'd1);
    chk({tag, "_id"}, m_id, id);
    chk({tag, "_bid"}, 64'(m_bid), 64'(bid));
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents one transaction from a negedge; returns at the negedge after it was accepted.
  task automatic push(input logic [63:0] id, input logic [D-1:0] rd, input logic [D-1:0] wr);
    logic ok;
    s_axis_tvalid = 1'b1;
    s_id = id;
    s_rd = rd;
    s_wr = wr;
    for (int n = 0; n < 50; n++) begin
      #1;
      ok = s_axis_tready;
      @(negedge clk);
      if (ok) return;
    end
    total++;
    fails++;
    $error("FAIL push_timeout observed=no_accept expected=accept id=%0d", id);
  endtask

  initial begin
    do_reset();
    chk("rst_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_done", 64'(batch_done), 64'd0);
    chk("rst_closed", 64'(closed_c), 64'd0);
    // Three disjoint transactions stream through batch 0.
    push(64'd1, bitv(1), bitv(101));
    chk("t1_lat", 64'(m_axis_tvalid), 64'd0);
    push(64'd2, bitv(2), bitv(102));
    out_is("t1_o1", 64'd1, 16'd0);
    push(64'd3, bitv(3), bitv(103));
    out_is("t1_o2", 64'd2, 16'd0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    out_is("t1_o3", 64'd3, 16'd0);
    chk("t1_nodone", 64'(batch_done), 64'd0);
    chk("t1_closed", 64'(closed_c), 64'd0);
    // RAW conflict closes batch 0.
    do_reset();
    push(64'd1, '0, bitv(5));
    push(64'd2, bitv(5), '0);
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("t2_done", 64'(batch_done), 64'd1);
    chk("t2_size", 64'(done_size), 64'd1);
    chk("t2_reason", 64'(done_reason), 64'd1);
    chk("t2_raw", raw_c, 64'd1);
    chk("t2_waw", waw_c, 64'd0);
    chk("t2_war", war_c, 64'd0);
    @(negedge clk);
    chk("t2_strobe", 64'(batch_done), 64'd0);
    @(negedge clk);
    out_is("t2_o2", 64'd2, 16'd1);
    // WAR then WAW conflicts.
    do_reset();
    push(64'd1, bitv(7), '0);
    push(64'd2, '0, bitv(7) | bitv(9));
    push(64'd3, '0, bitv(9));
    s_axis_tvalid = 1'b0;
    out_is("t3_o2", 64'd2, 16'd1);
    chk("t3_war", war_c, 64'd1);
    @(negedge clk);
    chk("t3_done", 64'(batch_done), 64'd1);
    chk("t3_waw", waw_c, 64'd1);
    chk("t3_raw", raw_c, 64'd0);
    chk("t3_war2", war_c, 64'd1);
    repeat (2) @(negedge clk);
    out_is("t3_o3", 64'd3, 16'd2);
    // Size limit: nine disjoint transactions.
    do_reset();
    for (int i = 1; i <= 9; i++) push(64'(i), bitv(i), bitv(100 + i));
    s_axis_tvalid = 1'b0;
    out_is("t4_o8", 64'd8, 16'd0);
    @(negedge clk);
    chk("t4_done", 64'(batch_done), 64'd1);
    chk("t4_size", 64'(done_size), 64'd8);
    chk("t4_reason", 64'(done_reason), 64'd2);
    chk("t4_closed", closed_c, 64'd1);
    repeat (2) @(negedge clk);
    out_is("t4_o9", 64'd9, 16'd1);
    // Backpressure continues batch 1.
    @(negedge clk);
    m_axis_tready = 1'b0;
    push(64'd11, bitv(20), bitv(120));
    push(64'd12, bitv(21), bitv(121));
    s_axis_tvalid = 1'b1;
    s_id = 64'd13;
    s_rd = bitv(22);
    s_wr = bitv(122);
    for (int k = 0; k < 5; k++) begin
      #1;
      out_is("t6_hold", 64'd11, 16'd1);
      chk("t6_rd_hold", 64'(m_rd == bitv(20)), 64'd1);
      chk("t6_tready", 64'(s_axis_tready), 64'd0);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    out_is("t6_o12", 64'd12, 16'd1);
    @(negedge clk);
    out_is("t6_o13", 64'd13, 16'd1);
    chk("t6_wr13", 64'(m_wr == bitv(122)), 64'd1);
    // Asynchronous reset mid-stall.
    m_axis_tready = 1'b0;
    push(64'd14, bitv(30), bitv(130));
    s_axis_tvalid = 1'b0;
    out_is("t7_held", 64'd13, 16'd1);
    chk("t7_closed_pre", closed_c, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_mvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t7_mid", m_id, 64'd0);
    chk("t7_bid", 64'(m_bid), 64'd0);
    chk("t7_closed", closed_c, 64'd0);
    chk("t7_done_size", 64'(done_size), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_dropped", 64'(m_axis_tvalid), 64'd0);
    // Idle timeout: one transaction, close 100 cycles after admit.
    do_reset();
    push(64'd1, bitv(1), bitv(101));
    s_axis_tvalid = 1'b0;
    repeat (100) @(negedge clk);
    chk("t5_early", 64'(batch_done), 64'd0);
    @(negedge clk);
    chk("t5_done", 64'(batch_done), 64'd1);
    chk("t5_reason", 64'(done_reason), 64'd3);
    chk("t5_size", 64'(done_size), 64'd1);
    @(negedge clk);
    chk("t5_strobe", 64'(batch_done), 64'd0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
